alu_operand_stage: RTL

- ID/EX pipeline stage directly upstream of the 64-bit ripple-carry adder (FA_64bit_sync) in the ALU of the 5-stage pipeline.
- Accepts decoded instructions from ID and resolves operands through EX/MEM and MEM/WB forwarding.
- Detects load-use hazards and inserts bubbles.
- Presents registered A, B, Cin and opcode to the EX-stage adder/logic unit under a valid/ready handshake.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_operand_stage_fwd_mux.sv | 55 +++++
 rtl/alu_operand_stage.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operand stage and its forwarding mux:
//   - default widths (XLEN, register index, opcode)
//   - ALU opcode encodings
//   - hazard FSM state encoding
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN_DEF      = 64;
    localparam int REG_IDX_W_DEF = 5;
    localparam int OP_W_DEF      = 3;

    // ALU opcodes. Encodings 6 and 7 are reserved and behave as ADD.
    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_PASSB = 3'd5;

    // Load-use hazard tracking.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Combinational forwarding select for one source operand.
// Priority: EX/MEM (unless it is a load, whose data is not ready yet),
// then MEM/WB, then the register file. Register index 0 always reads 0.
//
// Ports:
//   src_idx_i        source register index
//   rf_val_i         register-file read data
//   exmem_*_i        EX/MEM forward source (write enable, rd, value, is_load)
//   memwb_*_i        MEM/WB forward source (write enable, rd, value)
//   fwd_val_o        resolved operand value
// ---------------------------------------------------------------------------
module fwd_mux
    import alu_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF
) (
    input  logic [REG_IDX_W-1:0] src_idx_i,
    input  logic [XLEN-1:0]      rf_val_i,
    input  logic                 exmem_wr_en_i,
    input  logic [REG_IDX_W-1:0] exmem_rd_i,
    input  logic [XLEN-1:0]      exmem_val_i,
    input  logic                 exmem_is_load_i,
    input  logic                 memwb_wr_en_i,
    input  logic [REG_IDX_W-1:0] memwb_rd_i,
    input  logic [XLEN-1:0]      memwb_val_i,
    output logic [XLEN-1:0]      fwd_val_o
);

    logic idx_nonzero;
    logic exmem_hit;
    logic memwb_hit;

    assign idx_nonzero = (src_idx_i != '0);
    // A load in EX/MEM has no data yet; the hazard logic stalls instead.
    assign exmem_hit   = exmem_wr_en_i && (exmem_rd_i == src_idx_i) &&
                         idx_nonzero && !exmem_is_load_i;
    assign memwb_hit   = memwb_wr_en_i && (memwb_rd_i == src_idx_i) && idx_nonzero;

    always_comb begin
        fwd_val_o = '0;
        if (!idx_nonzero) begin
            fwd_val_o = '0;
        end else if (exmem_hit) begin
            fwd_val_o = exmem_val_i;
        end else if (memwb_hit) begin
            fwd_val_o = memwb_val_i;
        end else begin
            fwd_val_o = rf_val_i;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
// ID/EX pipeline register feeding the EX-stage ripple-carry adder and logic
// unit. Resolves both source operands through EX/MEM and MEM/WB forwarding,
// stalls one cycle on a load-use hazard (issuing a bubble), and presents
// registered A, B, Cin, opcode, destination and load flag under a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   id_valid / id_ready      ID-side handshake
//   id_op, id_is_load        decoded opcode and load flag
//   id_rs1_idx/val, id_rs2_idx/val   source indices and register-file data
//   id_use_imm, id_imm       immediate select and sign-extended immediate
//   id_rd_idx                destination register (0 = no write)
//   exmem_*, memwb_*         forwarding sources from later stages
//   flush                    branch redirect: kill held and incoming work
//   ex_valid / ex_ready      EX-side handshake
//   A, B, Cin                adder operands and carry-in
//   ex_op, ex_rd, ex_is_load registered instruction attributes
// ---------------------------------------------------------------------------
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF,
    parameter int OP_W      = OP_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [OP_W-1:0]      id_op,
    input  logic                 id_is_load,
    input  logic [REG_IDX_W-1:0] id_rs1_idx,
    input  logic [REG_IDX_W-1:0] id_rs2_idx,
    input  logic [XLEN-1:0]      id_rs1_val,
    input  logic [XLEN-1:0]      id_rs2_val,
    input  logic                 id_use_imm,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [REG_IDX_W-1:0] id_rd_idx,

    input  logic                 exmem_wr_en,
    input  logic [REG_IDX_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]      exmem_val,
    input  logic                 exmem_is_load,

    input  logic                 memwb_wr_en,
    input  logic [REG_IDX_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]      memwb_val,

    input  logic                 flush,

    input  logic                 ex_ready,
    output logic                 ex_valid,
    output logic [XLEN-1:0]      A,
    output logic [XLEN-1:0]      B,
    output logic                 Cin,
    output logic [OP_W-1:0]      ex_op,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic                 ex_is_load
);

    // ------------------------------------------------------------------
    // Forwarding: one mux per source operand
    // ------------------------------------------------------------------
    logic [XLEN-1:0]      fwd_val [2];
    logic [REG_IDX_W-1:0] src_idx [2];
    logic [XLEN-1:0]      rf_val  [2];

    assign src_idx[0] = id_rs1_idx;
    assign src_idx[1] = id_rs2_idx;
    assign rf_val[0]  = id_rs1_val;
    assign rf_val[1]  = id_rs2_val;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_mux #(
                .XLEN      (XLEN),
                .REG_IDX_W (REG_IDX_W)
            ) u_fwd_mux (
                .src_idx_i       (src_idx[gi]),
                .rf_val_i        (rf_val[gi]),
                .exmem_wr_en_i   (exmem_wr_en),
                .exmem_rd_i      (exmem_rd),
                .exmem_val_i     (exmem_val),
                .exmem_is_load_i (exmem_is_load),
                .memwb_wr_en_i   (memwb_wr_en),
                .memwb_rd_i      (memwb_rd),
                .memwb_val_i     (memwb_val),
                .fwd_val_o       (fwd_val[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load-use hazard and handshake
    // ------------------------------------------------------------------
    hz_state_e state_q;

    logic ex_valid_q;
    logic ex_free;
    logic hazard;
    logic stall;
    logic load_en;

    assign ex_free = !ex_valid_q || ex_ready;

    // rs2 is only a real dependency when the immediate is not selected.
    assign hazard = id_valid && exmem_is_load && exmem_wr_en &&
                    (exmem_rd != '0) &&
                    ((exmem_rd == id_rs1_idx) ||
                     ((exmem_rd == id_rs2_idx) && !id_use_imm));

    // STALL persists only while the owed bubble cannot yet be issued
    // because EX is still holding its previous instruction.
    assign stall   = hazard || ((state_q == ST_STALL) && !ex_free);
    assign load_en = ex_free && !stall;
    assign id_ready = rst_n && load_en;

    // ------------------------------------------------------------------
    // Operand mapping onto the adder inputs
    // ------------------------------------------------------------------
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] a_d;
    logic [XLEN-1:0] b_d;
    logic            cin_d;

    assign op_b = id_use_imm ? id_imm : fwd_val[1];

    always_comb begin
        a_d   = fwd_val[0];
        b_d   = op_b;
        cin_d = 1'b0;
        case (id_op)
            OP_W'(OP_SUB): begin
                // A - B == A + ~B + 1
                b_d   = ~op_b;
                cin_d = 1'b1;
            end
            OP_W'(OP_PASSB): begin
                a_d = '0;
            end
            default: begin
                // ADD, AND, OR, XOR and the reserved encodings share the
                // straight mapping; the logic unit reads A/B directly.
                a_d   = fwd_val[0];
                b_d   = op_b;
                cin_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers and hazard FSM
    // ------------------------------------------------------------------
    logic [XLEN-1:0]      a_q;
    logic [XLEN-1:0]      b_q;
    logic                 cin_q;
    logic [OP_W-1:0]      op_q;
    logic [REG_IDX_W-1:0] rd_q;
    logic                 is_load_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            ex_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            op_q       <= '0;
            rd_q       <= '0;
            is_load_q  <= 1'b0;
        end else if (flush) begin
            // Redirect kills both the held and the incoming instruction.
            // Data registers are left stale; ex_valid guards them.
            state_q    <= ST_RUN;
            ex_valid_q <= 1'b0;
        end else begin
            state_q <= stall ? ST_STALL : ST_RUN;
            if (load_en) begin
                ex_valid_q <= id_valid;
                if (id_valid) begin
                    a_q       <= a_d;
                    b_q       <= b_d;
                    cin_q     <= cin_d;
                    op_q      <= id_op;
                    rd_q      <= id_rd_idx;
                    is_load_q <= id_is_load;
                end
            end else if (ex_free) begin
                // Stalled with EX free: issue the bubble.
                ex_valid_q <= 1'b0;
            end
        end
    end

    assign ex_valid   = ex_valid_q;
    assign A          = a_q;
    assign B          = b_q;
    assign Cin        = cin_q;
    assign ex_op      = op_q;
    assign ex_rd      = rd_q;
    assign ex_is_load = is_load_q;

endmodule
